hash_table_arbiter: RTL and testbench

- Front-end scheduler that shares one hash_table instance between NUM_REQ requesters.
- Each requester has a valid/ready request channel (op, key, data) and a valid/ready response channel.
- Round-robin grant; exactly one operation is outstanding in the table at a time.
- Issues a single-cycle op to the table, waits a fixed latency, captures read data and the matching status flag, then returns the result to the granted requester.

---
 rtl/hash_table_pkg.sv | 40 ++++
 rtl/hash_rr_arbiter.sv | 35 +++
 rtl/hash_table_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_hash_table_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared types for the hash-table front-end arbiter: op/status encodings,
// FSM state constants and the status-selection rule.
package hash_table_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK            = 2'b00,
    ST_NO_DEL_TARGET = 2'b01,
    ST_NO_SPACE      = 2'b10,
    ST_NOT_FOUND     = 2'b11
  } status_e;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  // Only the flag belonging to the issued op can fail it.
  function automatic status_e op_status(input op_e op, input logic no_del,
                                        input logic no_space, input logic not_found);
    status_e st;
    st = ST_OK;
    case (op)
      OP_WRITE:  if (no_space)  st = ST_NO_SPACE;
      OP_DELETE: if (no_del)    st = ST_NO_DEL_TARGET;
      OP_READ:   if (not_found) st = ST_NOT_FOUND;
      default:   st = ST_OK;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/hash_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping, as a one-hot grant plus its index.
module hash_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  int          pos;
  logic [IDW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    j     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= int'(NUM_REQ)) pos = pos - int'(NUM_REQ);
      j = IDW'(pos);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/hash_table_arbiter.sv
// Shares one hash_table between NUM_REQ requesters, one op in flight at a time.
// Optional HASH_TABLE_ARBITER_STATS_EN adds saturating op/fail counters.
module hash_table_arbiter
  import hash_table_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned HT_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*2-1:0]          req_op_i,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]  req_key_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  input  logic [NUM_REQ-1:0]            resp_ready_i,
  output logic [DATA_WIDTH-1:0]         resp_data_o,
  output logic [1:0]                    resp_status_o,
  output logic [KEY_WIDTH-1:0]          ht_key_o,
  output logic [DATA_WIDTH-1:0]         ht_data_o,
  output logic [1:0]                    ht_op_o,
  input  logic [DATA_WIDTH-1:0]         ht_read_data_i,
  input  logic                          ht_no_deletion_target_i,
  input  logic                          ht_no_write_space_i,
  input  logic                          ht_no_element_found_i
`ifdef HASH_TABLE_ARBITER_STATS_EN
  ,
  output logic [15:0]                   stat_ops_o,
  output logic [15:0]                   stat_fail_o
`endif
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW  = $clog2(HT_LATENCY + 1);

  state_t                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d, id_q, id_d;
  op_e                    op_q, op_d, ht_op_q, ht_op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d, rdata_q, rdata_d;
  status_e                status_q, status_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0]     req_ready_c;

  logic [NUM_REQ-1:0]     gnt_oh;
  logic [IDW-1:0]         gnt_idx;
  logic                   gnt_any;
  op_e                    sel_op;
  logic [KEY_WIDTH-1:0]   sel_key;
  logic [DATA_WIDTH-1:0]  sel_data;

  hash_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Payload of the granted requester.
  always_comb begin
    sel_op   = OP_NOP;
    sel_key  = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_oh[i]) begin
        sel_op   = op_e'(req_op_i[i*2 +: 2]);
        sel_key  = req_key_i[i*KEY_WIDTH +: KEY_WIDTH];
        sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    key_d       = key_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    req_ready_c = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          req_ready_c = gnt_oh;
          id_d        = gnt_idx;
          op_d        = sel_op;
          key_d       = sel_key;
          data_d      = sel_data;
          ptr_d       = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A NOP never touches the table and answers straight away.
        if (op_q == OP_NOP) begin
          rdata_d  = '0;
          status_d = ST_OK;
          state_d  = S_RESP;
        end else begin
          cnt_d   = CW'(HT_LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d  = (op_q == OP_READ) ? ht_read_data_i : '0;
          status_d = op_status(op_q, ht_no_deletion_target_i,
                               ht_no_write_space_i, ht_no_element_found_i);
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i[id_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ht_op_d      = (state_d == S_ISSUE) ? op_d : OP_NOP;
    resp_valid_d = (state_d == S_RESP) ? (NUM_REQ'(1) << id_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      op_q         <= OP_NOP;
      ht_op_q      <= OP_NOP;
      key_q        <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      status_q     <= ST_OK;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      op_q         <= op_d;
      ht_op_q      <= ht_op_d;
      key_q        <= key_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready_o   = reset ? req_ready_c : '0;
  assign resp_valid_o  = resp_valid_q;
  assign resp_data_o   = rdata_q;
  assign resp_status_o = 2'(status_q);
  assign ht_key_o      = key_q;
  assign ht_data_o     = data_q;
  assign ht_op_o       = 2'(ht_op_q);

`ifdef HASH_TABLE_ARBITER_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d, stat_fail_q, stat_fail_d;

  // Count completed table ops and the ones that came back with a failure.
  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_fail_d = stat_fail_q;
    if (state_q == S_RESP && resp_ready_i[id_q] && op_q != OP_NOP) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_d = stat_ops_q + 16'd1;
      if (status_q != ST_OK && stat_fail_q != 16'hFFFF) stat_fail_d = stat_fail_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_ops_q  <= '0;
      stat_fail_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_fail_q <= stat_fail_d;
    end
  end

  assign stat_ops_o  = stat_ops_q;
  assign stat_fail_o = stat_fail_q;
`endif

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Self-checking bench for hash_table_arbiter: directed scenarios followed by
// randomized single-requester transactions against a rule-level model.
module tb_hash_table_arbiter;

  localparam int N  = 3;
  localparam int KW = 2;
  localparam int DW = 8;
  localparam int L  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req_valid, resp_ready;
  logic [1:0]      op_a   [N];
  logic [KW-1:0]   key_a  [N];
  logic [DW-1:0]   data_a [N];
  logic [2*N-1:0]  req_op;
  logic [N*KW-1:0] req_key;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   ht_rdata;
  logic            f_del, f_space, f_nf;

  logic [N-1:0]    req_ready_o, resp_valid_o;
  logic [DW-1:0]   resp_data_o, ht_data_o;
  logic [1:0]      resp_status_o, ht_op_o;
  logic [KW-1:0]   ht_key_o;
`ifdef HASH_TABLE_ARBITER_STATS_EN
  logic [15:0]     stat_ops_o, stat_fail_o;
`endif

  int compared = 0;
  int mismatched = 0;
  int ptr_m = 0;
  int ops_m = 0;
  int fails_m = 0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op[i*2 +: 2]     = op_a[i];
      req_key[i*KW +: KW]  = key_a[i];
      req_data[i*DW +: DW] = data_a[i];
    end
  end

  hash_table_arbiter #(
    .KEY_WIDTH (KW), .DATA_WIDTH (DW), .NUM_REQ (N), .HT_LATENCY (L)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req_valid_i             (req_valid),
    .req_ready_o             (req_ready_o),
    .req_op_i                (req_op),
    .req_key_i               (req_key),
    .req_data_i              (req_data),
    .resp_valid_o            (resp_valid_o),
    .resp_ready_i            (resp_ready),
    .resp_data_o             (resp_data_o),
    .resp_status_o           (resp_status_o),
    .ht_key_o                (ht_key_o),
    .ht_data_o               (ht_data_o),
    .ht_op_o                 (ht_op_o),
    .ht_read_data_i          (ht_rdata),
    .ht_no_deletion_target_i (f_del),
    .ht_no_write_space_i     (f_space),
    .ht_no_element_found_i   (f_nf)
`ifdef HASH_TABLE_ARBITER_STATS_EN
    ,
    .stat_ops_o              (stat_ops_o),
    .stat_fail_o             (stat_fail_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Status rule: each op only reports its own flag.
  function automatic logic [1:0] exp_status(input logic [1:0] op, input logic d,
                                            input logic s, input logic n);
    case (op)
      2'b01:   return s ? 2'b10 : 2'b00;
      2'b10:   return n ? 2'b11 : 2'b00;
      2'b11:   return d ? 2'b01 : 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready_o),   0);
    chk({tag, "_resp_valid"}, 32'(resp_valid_o),  0);
    chk({tag, "_resp_data"},  32'(resp_data_o),   0);
    chk({tag, "_resp_stat"},  32'(resp_status_o), 0);
    chk({tag, "_ht_key"},     32'(ht_key_o),      0);
    chk({tag, "_ht_data"},    32'(ht_data_o),     0);
    chk({tag, "_ht_op"},      32'(ht_op_o),       0);
  endtask

  // One request from requester r with the table answering with the given flags.
  task automatic run_txn(input logic [1:0] r, input logic [1:0] op, input logic [KW-1:0] key,
                         input logic [DW-1:0] data, input logic d, input logic s,
                         input logic n, input logic [DW-1:0] rd, input int delay);
    int k, w, nissue, lat;
    logic got;
    logic [1:0] est;
    logic [DW-1:0] edata;
    est   = exp_status(op, d, s, n);
    edata = (op == 2'b10) ? rd : '0;
    lat   = (op == 2'b00) ? 2 : 2 + L;
    f_del = d; f_space = s; f_nf = n; ht_rdata = rd;
    op_a[r] = op; key_a[r] = key; data_a[r] = data;
    req_valid = '0;
    req_valid[r] = 1'b1;
    #1;
    w = 0;
    while (!req_ready_o[r] && w < 20) begin
      tick;
      w++;
    end
    chk("grant_seen", 32'(w < 20), 1);
    chk("grant_onehot", 32'(req_ready_o), 32'(1) << r);
    tick;
    req_valid = '0;
    ptr_m = (int'(r) + 1) % N;
    k = 1; got = 1'b0; nissue = 0;
    while (!got && k <= 12) begin
      if (ht_op_o != 2'b00) nissue++;
      if (k == 1) begin
        chk("issue_op",   32'(ht_op_o),   32'(op));
        chk("issue_key",  32'(ht_key_o),  32'(key));
        chk("issue_data", 32'(ht_data_o), 32'(data));
      end
      if (k == 2 && op != 2'b00) chk("wait_key_hold", 32'(ht_key_o), 32'(key));
      if (resp_valid_o != '0) got = 1'b1;
      else begin
        tick;
        k++;
      end
    end
    chk("resp_seen", 32'(got), 1);
    chk("resp_latency", k, lat);
    chk("issue_cycles", nissue, (op == 2'b00) ? 0 : 1);
    chk("resp_onehot", 32'(resp_valid_o), 32'(1) << r);
    chk("resp_data", 32'(resp_data_o), 32'(edata));
    chk("resp_status", 32'(resp_status_o), 32'(est));
    for (int i = 0; i < delay; i++) begin
      req_valid  = '1;
      resp_ready = ~(N'(1) << r);
      #1;
      chk("hold_no_grant", 32'(req_ready_o), 0);
      chk("hold_valid",  32'(resp_valid_o),  32'(1) << r);
      chk("hold_data",   32'(resp_data_o),   32'(edata));
      chk("hold_status", 32'(resp_status_o), 32'(est));
      tick;
    end
    req_valid  = '0;
    resp_ready = '0;
    resp_ready[r] = 1'b1;
    tick;
    resp_ready = '0;
    chk("resp_dropped", 32'(resp_valid_o), 0);
    if (op != 2'b00) begin
      ops_m++;
      if (est != 2'b00) fails_m++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, lastc, ngr, g;
    logic [1:0] rr, rop;

    reset = 1'b0; req_valid = '1; resp_ready = '1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 2'b01; key_a[i] = KW'(i); data_a[i] = DW'(8'hA5);
    end
    ht_rdata = 8'h5C; f_del = 1'b1; f_space = 1'b1; f_nf = 1'b1;
    tick; tick;
    chk_zero("reset");
    req_valid = '0; resp_ready = '0;
    f_del = 1'b0; f_space = 1'b0; f_nf = 1'b0;
    reset = 1'b1;
    tick;

    // Write, reads (hit / miss), held response, delete miss, NOP.
    run_txn(2'd0, 2'b01, 2'b00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h3C, 0);
    run_txn(2'd1, 2'b10, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 0);
    run_txn(2'd1, 2'b10, 2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 0);
    run_txn(2'd2, 2'b01, 2'b10, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h33, 5);
    run_txn(2'd2, 2'b11, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h77, 0);
    run_txn(2'd2, 2'b00, 2'b01, 8'h12, 1'b1, 1'b1, 1'b1, 8'h99, 0);

    // Reset while the table op is in flight.
    op_a[1] = 2'b10; key_a[1] = 2'b01; ht_rdata = 8'hEE;
    req_valid = 3'b010;
    #1;
    chk("rst_pre_grant", 32'(req_ready_o), 32'b010);
    tick;
    req_valid = '0;
    tick;
    reset = 1'b0;
    tick;
    chk_zero("reset_wait");
    tick;
    reset = 1'b1;
    ptr_m = 0; ops_m = 0; fails_m = 0;
    for (int i = 0; i < 5; i++) begin
      chk("no_stale_resp", 32'(resp_valid_o), 0);
      tick;
    end

    // All requesters hold valid, responses accepted at once.
    op_a[0] = 2'b01; op_a[1] = 2'b10; op_a[2] = 2'b11;
    req_valid = '1; resp_ready = '1;
    #1;
    c = 0; lastc = 0; ngr = 0;
    while (ngr < 6 && c < 60) begin
      chk("rr_onehot", 32'($countones(req_ready_o) <= 1), 1);
      if (req_ready_o != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (((req_ready_o >> i) & 1) != 0) g = i;
        chk("rr_order", g, ptr_m);
        if (ngr > 0) chk("rr_gap", c - lastc, 3 + L);
        lastc = c;
        ptr_m = (g + 1) % N;
        ngr++;
        ops_m++;
      end
      tick;
      c++;
    end
    chk("rr_grants", ngr, 6);
    req_valid = '0;
    for (int i = 0; i < 6; i++) tick;
    chk("rr_drained", 32'(resp_valid_o), 0);
    resp_ready = '0;

    // Randomized single-requester traffic.
    for (int t = 0; t < 30; t++) begin
      rr  = 2'($urandom_range(0, N - 1));
      rop = 2'($urandom_range(0, 3));
      run_txn(rr, rop, KW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), DW'($urandom), int'($urandom_range(0, 3)));
    end

`ifdef HASH_TABLE_ARBITER_STATS_EN
    chk("stat_ops",  32'(stat_ops_o),  ops_m);
    chk("stat_fail", 32'(stat_fail_o), fails_m);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
